// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared types and constants for the pipelined MIPS core.
//               Fetch-stage FSM states, redirect encodings and the bubble
//               instruction word.
// Revision    : 1.0 - initial fetch-stage additions
// ============================================================================
package cpu_types_pkg;

  // Fetch FSM: normal fetch, waiting out a miss with a pending redirect,
  // and frozen after halt.
  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } fetch_state_t;

  // Redirect request types coming back from later pipeline stages.
  typedef enum logic [1:0] {
    REDIR_NONE = 2'b00,
    REDIR_J    = 2'b01,
    REDIR_JR   = 2'b10,
    REDIR_BR   = 2'b11
  } redir_t;

  // sll $0,$0,0 -- the word presented on IF/ID for a bubble.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_if
// Description : Signal bundle for the fetch stage.
//               fs : view of the fetch block (I-cache, hazard, redirect in;
//                    fetch address and IF/ID latch out).
//               tb : view of the bench driving and observing the block.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        stall;
  logic        halt;
  logic [1:0]  redir_sel;
  logic [31:0] redir_npc;
  logic [25:0] redir_j25;
  logic [15:0] redir_imm16;
  logic [31:0] redir_rs;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_npc;
  logic        ifid_valid;

  modport fs (
    input  ihit, imemload, stall, halt,
    input  redir_sel, redir_npc, redir_j25, redir_imm16, redir_rs,
    output imemREN, imemaddr, ifid_instr, ifid_npc, ifid_valid
  );

  modport tb (
    output ihit, imemload, stall, halt,
    output redir_sel, redir_npc, redir_j25, redir_imm16, redir_rs,
    input  imemREN, imemaddr, ifid_instr, ifid_npc, ifid_valid
  );
endinterface : fetch_stage_if
`default_nettype wire

// File: rtl/npc_calc.sv
`default_nettype none
// ============================================================================
// Module      : npc_calc
// Description : Combinational redirect-target calculator.
// Ports       : redir_sel  - redirect type (none/J/JR/branch)
//               npc        - PC+4 of the redirecting instruction
//               j25        - jump index
//               imm16      - branch offset (words, signed)
//               rs         - JR register value
//               target     - resulting fetch address
// Revision    : 1.0 - initial release
// ============================================================================
module npc_calc
  import cpu_types_pkg::*;
(
  input  logic [1:0]  redir_sel,
  input  logic [31:0] npc,
  input  logic [25:0] j25,
  input  logic [15:0] imm16,
  input  logic [31:0] rs,
  output logic [31:0] target
);

  always_comb begin
    target = npc;
    case (redir_sel)
      REDIR_J:  target = {npc[31:28], j25, 2'b00};
      // JR target is taken verbatim, even if unaligned.
      REDIR_JR: target = rs;
      REDIR_BR: target = npc + {{14{imm16[15]}}, imm16, 2'b00};
      default:  target = npc;
    endcase
  end

endmodule : npc_calc
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage with PC, redirect handling across
//               I-cache misses, hazard stall, halt freeze and IF/ID latch.
// Ports       : CLK, nRST            - clock, async active-low reset
//               ihit, imemload       - I-cache response
//               imemREN, imemaddr    - I-cache request (addr == PC)
//               stall, halt          - hazard hold / retired halt
//               redir_*              - redirect request from later stages
//               ifid_instr/npc/valid - IF/ID latch toward decode
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        halt,
  input  logic [1:0]  redir_sel,
  input  logic [31:0] redir_npc,
  input  logic [25:0] redir_j25,
  input  logic [15:0] redir_imm16,
  input  logic [31:0] redir_rs,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_npc,
  output logic        ifid_valid
);

  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_n;
  logic [31:0]  pend_pc, pend_pc_n;
  logic [31:0]  instr_n, npc_n;
  logic         valid_n;
  logic [31:0]  target;
  logic [31:0]  pc_plus4;
  logic         redir;

  npc_calc u_npc_calc (
    .redir_sel (redir_sel),
    .npc       (redir_npc),
    .j25       (redir_j25),
    .imm16     (redir_imm16),
    .rs        (redir_rs),
    .target    (target)
  );

  assign redir    = (redir_sel != REDIR_NONE);
  assign pc_plus4 = pc + 32'd4;
  assign imemaddr = pc;
  assign imemREN  = (state != HALTED);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= RUN;
      pc         <= PC_INIT;
      pend_pc    <= '0;
      ifid_instr <= NOP_INSTR;
      ifid_npc   <= '0;
      ifid_valid <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      pend_pc    <= pend_pc_n;
      ifid_instr <= instr_n;
      ifid_npc   <= npc_n;
      ifid_valid <= valid_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    pend_pc_n = pend_pc;
    instr_n   = ifid_instr;
    npc_n     = ifid_npc;
    valid_n   = ifid_valid;

    if (state == HALTED || halt) begin
      // Halt beats everything and is sticky until reset.
      state_n = HALTED;
      instr_n = NOP_INSTR;
      npc_n   = '0;
      valid_n = 1'b0;
    end else if (state == DRAIN) begin
      instr_n = NOP_INSTR;
      npc_n   = '0;
      valid_n = 1'b0;
      if (redir) pend_pc_n = target;
      if (ihit) begin
        // Drained word is dropped; a redirect in this same cycle wins.
        pc_n    = redir ? target : pend_pc;
        state_n = RUN;
      end
    end else if (redir) begin
      instr_n = NOP_INSTR;
      npc_n   = '0;
      valid_n = 1'b0;
      if (ihit) begin
        pc_n = target;
      end else begin
        // Keep PC steady so the outstanding miss completes at its address.
        pend_pc_n = target;
        state_n   = DRAIN;
      end
    end else if (!stall) begin
      if (ihit) begin
        instr_n = imemload;
        npc_n   = pc_plus4;
        valid_n = 1'b1;
        pc_n    = pc_plus4;
      end else begin
        instr_n = NOP_INSTR;
        npc_n   = '0;
        valid_n = 1'b0;
      end
    end
  end

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage. Directed scenarios and
//               randomized traffic compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;
  import cpu_types_pkg::*;

  logic clk;
  logic nrst;
  int   errors = 0;
  int   checks = 0;

  fetch_stage_if fif ();

  // Reference model: mode 0 = fetching, 1 = waiting for a miss to drain
  // with a pending target, 2 = halted.
  int          m_mode;
  logic [31:0] m_pc, m_pend, m_instr, m_npc;
  logic        m_valid;

  fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
    .CLK         (clk),
    .nRST        (nrst),
    .ihit        (fif.ihit),
    .imemload    (fif.imemload),
    .imemREN     (fif.imemREN),
    .imemaddr    (fif.imemaddr),
    .stall       (fif.stall),
    .halt        (fif.halt),
    .redir_sel   (fif.redir_sel),
    .redir_npc   (fif.redir_npc),
    .redir_j25   (fif.redir_j25),
    .redir_imm16 (fif.redir_imm16),
    .redir_rs    (fif.redir_rs),
    .ifid_instr  (fif.ifid_instr),
    .ifid_npc    (fif.ifid_npc),
    .ifid_valid  (fif.ifid_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_target();
    case (fif.redir_sel)
      2'd1:    return (fif.redir_npc & 32'hF000_0000) | (32'(fif.redir_j25) * 32'd4);
      2'd2:    return fif.redir_rs;
      default: return fif.redir_npc + 32'(int'($signed(fif.redir_imm16)) * 4);
    endcase
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_pc    = 32'h0;
    m_pend  = 32'h0;
    m_instr = 32'h0;
    m_npc   = 32'h0;
    m_valid = 1'b0;
  endtask

  task automatic model_bubble();
    m_instr = 32'h0;
    m_valid = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] t;
    t = ref_target();
    if (m_mode == 2 || fif.halt) begin
      m_mode = 2;
      model_bubble();
    end else if (m_mode == 1) begin
      model_bubble();
      if (fif.redir_sel != 2'b00) m_pend = t;
      if (fif.ihit) begin
        m_pc   = m_pend;
        m_mode = 0;
      end
    end else if (fif.redir_sel != 2'b00) begin
      model_bubble();
      if (fif.ihit) m_pc = t;
      else begin
        m_pend = t;
        m_mode = 1;
      end
    end else if (!fif.stall) begin
      if (fif.ihit) begin
        m_instr = fif.imemload;
        m_npc   = m_pc + 32'd4;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
      end else begin
        model_bubble();
      end
    end
  endtask

  // One clock: compare outputs mid-cycle, advance the model with the inputs
  // that will be sampled at the coming edge, return just after that edge.
  task automatic cyc();
    @(negedge clk);
    check("imemaddr", fif.imemaddr, m_pc);
    check("imemREN", {31'b0, fif.imemREN}, {31'b0, (m_mode != 2)});
    check("ifid_valid", {31'b0, fif.ifid_valid}, {31'b0, m_valid});
    check("ifid_instr", fif.ifid_instr, m_instr);
    if (m_valid) check("ifid_npc", fif.ifid_npc, m_npc);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fif.ihit        = 1'b0;
    fif.imemload    = 32'h0;
    fif.stall       = 1'b0;
    fif.halt        = 1'b0;
    fif.redir_sel   = 2'b00;
    fif.redir_npc   = 32'h0;
    fif.redir_j25   = 26'h0;
    fif.redir_imm16 = 16'h0;
    fif.redir_rs    = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    check("rst_addr", fif.imemaddr, 32'h0);
    check("rst_ren", {31'b0, fif.imemREN}, 32'h1);
    check("rst_valid", {31'b0, fif.ifid_valid}, 32'h0);
    check("rst_instr", fif.ifid_instr, 32'h0);
    check("rst_npc", fif.ifid_npc, 32'h0);
    model_reset();
    @(posedge clk);
    #1 nrst = 1'b1;
  endtask

  task automatic hit(input logic [31:0] word);
    idle_inputs();
    fif.ihit     = 1'b1;
    fif.imemload = word;
    cyc();
  endtask

  initial begin
    nrst = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    do_reset();

    // Back-to-back hits.
    hit(32'hA);
    check("seq_npc0", fif.ifid_npc, 32'h4);
    hit(32'hB);
    hit(32'hC);
    check("seq_addr", fif.imemaddr, 32'hC);
    hit(32'hD);

    // Two-cycle stall with ihit at PC 0x10.
    idle_inputs();
    fif.ihit = 1'b1; fif.imemload = 32'h1111; fif.stall = 1'b1;
    cyc();
    cyc();
    check("stall_pc", fif.imemaddr, 32'h10);
    check("stall_instr", fif.ifid_instr, 32'hD);
    hit(32'hE);
    check("resume_instr", fif.ifid_instr, 32'hE);

    // Taken branch backwards, with hit.
    idle_inputs();
    fif.ihit = 1'b1; fif.imemload = 32'h5555;
    fif.redir_sel = 2'b11; fif.redir_npc = 32'h20; fif.redir_imm16 = 16'hFFFE;
    cyc();
    check("br_addr", fif.imemaddr, 32'h18);
    check("br_bubble", {31'b0, fif.ifid_valid}, 32'h0);

    // Jump during a three-cycle miss.
    idle_inputs();
    fif.redir_sel = 2'b01; fif.redir_npc = 32'h9000_0004; fif.redir_j25 = 26'h40;
    cyc();
    idle_inputs();
    cyc();
    cyc();
    check("miss_hold", fif.imemaddr, 32'h18);
    hit(32'hDEAD);
    check("j_addr", fif.imemaddr, 32'h9000_0100);
    check("j_drop", {31'b0, fif.ifid_valid}, 32'h0);

    // Two redirects while draining: last one wins.
    idle_inputs();
    fif.redir_sel = 2'b10; fif.redir_rs = 32'h100;
    cyc();
    idle_inputs();
    fif.redir_sel = 2'b11; fif.redir_npc = 32'h1FC; fif.redir_imm16 = 16'h0001;
    cyc();
    idle_inputs();
    cyc();
    check("drain_hold", fif.imemaddr, 32'h9000_0100);
    hit(32'hBEEF);
    check("last_wins", fif.imemaddr, 32'h200);

    // Halt, then traffic that must be ignored.
    idle_inputs();
    fif.halt = 1'b1; fif.ihit = 1'b1;
    cyc();
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      fif.ihit = 1'b1; fif.imemload = $urandom;
      fif.redir_sel = 2'b10; fif.redir_rs = $urandom;
      cyc();
    end
    check("halt_ren", {31'b0, fif.imemREN}, 32'h0);
    check("halt_pc", fif.imemaddr, 32'h200);
    do_reset();

    // PC+4 wrap at the top of the address space.
    idle_inputs();
    fif.ihit = 1'b1; fif.redir_sel = 2'b10; fif.redir_rs = 32'hFFFF_FFFC;
    cyc();
    check("wrap_pre", fif.imemaddr, 32'hFFFF_FFFC);
    hit(32'h1234);
    check("wrap_pc", fif.imemaddr, 32'h0);
    check("wrap_npc", fif.ifid_npc, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      if ((m_mode == 2 && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0)
        do_reset();
      fif.ihit        = ($urandom_range(0, 9) < 7);
      fif.imemload    = $urandom;
      fif.stall       = ($urandom_range(0, 4) == 0);
      fif.halt        = ($urandom_range(0, 149) == 0);
      fif.redir_sel   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      fif.redir_npc   = $urandom;
      fif.redir_j25   = 26'($urandom);
      fif.redir_imm16 = 16'($urandom);
      fif.redir_rs    = $urandom;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fetch_stage
`default_nettype wire
